serial_decoder: RTL and testbench
=================================

Name: serial_decoder

Overview:
- Receiving end of the 1-bit serial output line driven by the encoder/decoder datapath.
- Deserialises a framed CODE_W-bit code from `rx`: start bit, CODE_W data bits LSB first, optional parity bit, stop bit.
- Decodes the code to a registered one-hot vector and flags it with a single-cycle `valid`.
- Sits between the board input pin and the LED/one-hot consumers; framing violations are reported on `err`.

Parameters:
- CODE_W, 2, code width in bits; one-hot width is 2**CODE_W; legal range 1..4.
- DIV, 16, clocks per serial bit; must be even and >= 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  serial line, idle high, asynchronous to clk.
- onehot  output  2**CODE_W  decoded one-hot of the last good code.
- code  output  CODE_W  binary value of the last good code.
- valid  output  1  one-cycle pulse when onehot/code update.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- err  output  1  one-cycle pulse on framing (or parity) error.

Behaviour:
- Reset values: onehot=0, code=0, valid=0, err=0, busy=0, FSM=IDLE, synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s). Falling-edge detect: previous rx_s=1 and current rx_s=0.
- FSM states: IDLE, START, DATA, PARITY (only with feature), STOP.
- IDLE:
  - On falling edge, load the bit counter with DIV/2-1 and go to START.
  - A line held low (break) cannot retrigger because an edge requires a prior 1.
- START:
  - At counter expiry (mid-bit), sample rx_s.
  - If 0, reload DIV-1 and go to DATA with bit index 0.
  - If 1, treat as a glitch: return to IDLE with no err.
- DATA:
  - At each expiry, shift rx_s into the shift register at position index (LSB first).
  - After bit CODE_W-1, go to PARITY if enabled, else STOP.
- STOP:
  - At expiry, sample rx_s.
  - If 1: next cycle code <= shift register, onehot <= 1<<shift register, valid=1 for one cycle.
  - If 0: err=1 for one cycle, onehot/code unchanged.
  - Return to IDLE in both cases.
- Timing (t0 = first clk where input rx is low):
  - Start sampled at t0+2+DIV/2.
  - Data bit i sampled at t0+2+DIV/2+(i+1)*DIV.
  - Stop bit sampled at t0+2+DIV/2+(CODE_W+1)*DIV; valid/err asserted the following cycle.
- Back-to-back frames: a falling edge on the cycle after the stop sample is accepted; no idle gap is required beyond the stop bit.
- onehot and code hold their value between frames; only valid pulses.
- valid and err are never high together.
- rst mid-frame aborts immediately: FSM=IDLE, partial shift data discarded, outputs return to reset values.
- Counter width: $clog2(DIV). Bit index width: $clog2(CODE_W+1).

Optional Feature:
- Macro: SERIAL_DECODER_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; one even-parity bit is expected over the CODE_W data bits.
  - A mismatch is latched, and at STOP the frame produces err instead of valid, even if the stop bit is good.
  - Stop sample moves one DIV later.
- Undefined: no PARITY state, no parity logic; frame length is CODE_W+2 bits.

Decomposition:
- Shared package serial_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit).
  - Line idle level constant (1).
  - Helper function for even parity over a vector.
- One sub-module, rx_sync_edge: 2-flop synchroniser with reset-to-1 and falling-edge pulse output.
- Code-to-one-hot is an inline shift; the existing combinational decoder is not reused.

Test Plan:
- DIV=4, CODE_W=2, frame 0,0,1,1 (start, bits LSB first: code 2'b10, stop) -> at t0+17: valid=1 one cycle, code=2, onehot=4'b0100, err=0.
- Two frames back-to-back, code 3 then code 0 -> valid pulses 16 cycles apart; onehot 4'b1000, then 4'b0001.
- Stop bit driven 0, code 1 -> err=1 one cycle at t0+17, valid=0, onehot keeps previous value 4'b0100.
- rx low for 1 clk only (glitch) -> start sample reads 1, FSM back to IDLE, no valid, no err, busy high for DIV/2+2 cycles only.
- rst asserted mid-DATA of a code-3 frame -> next cycle busy=0, onehot=0, code=0; no valid for the aborted frame.
- With SERIAL_DECODER_PARITY_EN, code 2'b11 with parity bit 1 -> err pulse at t0+21; with parity bit 0 -> valid, onehot 4'b1000.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding,
// line idle level and an even-parity helper.
package serial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam logic LINE_IDLE = 1'b1;

   // Even-parity bit over a zero-extended vector (widest code is 4 bits).
   function automatic logic even_parity(input logic [7:0] vec);
      return ^vec;
   endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchroniser for the asynchronous serial line, followed by a
// history flop that produces a one-cycle falling-edge pulse. All flops reset
// to the idle line level so that a line held low out of reset is not an edge.
module rx_sync_edge
   import serial_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic rx_s_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchroniser chain plus one flop of history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= LINE_IDLE;
         sync_q <= LINE_IDLE;
         prev_q <= LINE_IDLE;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_s_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/serial_decoder.sv
// Serial frame receiver: start bit, CODE_W data bits LSB first, optional
// even-parity bit, stop bit. A good frame updates code/onehot and pulses
// valid; a framing or parity error pulses err and leaves code/onehot alone.
// Build option: define SERIAL_DECODER_PARITY_EN to expect a parity bit.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a falling edge on the synchronised line
// ST_START  | half-bit wait, then confirm the start bit is still low
// ST_DATA   | sampling data bits mid-bit, LSB first
// ST_PARITY | sampling the parity bit and latching a mismatch
// ST_STOP   | sampling the stop bit, then publishing the code or an error
module serial_decoder
   import serial_pkg::*;
#(
   parameter int CODE_W = 2,
   parameter int DIV    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [(1<<CODE_W)-1:0]   onehot,
   output logic [CODE_W-1:0]        code,
   output logic                     valid,
   output logic                     busy,
   output logic                     err
);

   localparam int OH_W  = 1 << CODE_W;
   localparam int CNT_W = $clog2(DIV);
   localparam int IDX_W = $clog2(CODE_W + 1);

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_W - 1);

   logic                rx_s;
   logic                fall;

   rx_state_e           state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [CODE_W-1:0]   shift_q;
   logic [CODE_W-1:0]   code_q;
   logic [OH_W-1:0]     onehot_q;
   logic                valid_q;
   logic                err_q;
`ifdef SERIAL_DECODER_PARITY_EN
   logic                par_err_q;
`endif

   logic                expired;

   rx_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .rx_i   (rx),
      .rx_s_o (rx_s),
      .fall_o (fall)
   );

   assign expired = (cnt_q == '0);

   // Frame FSM with bit timer, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         code_q    <= '0;
         onehot_q  <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
`ifdef SERIAL_DECODER_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall) begin
                  cnt_q   <= CNT_HALF;
                  state_q <= ST_START;
               end
            end

            ST_START: begin
               if (!expired) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (rx_s == LINE_IDLE) begin
                  // Line went back high before mid-bit: a glitch, not a frame.
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q     <= CNT_FULL;
                  idx_q     <= '0;
                  shift_q   <= '0;
`ifdef SERIAL_DECODER_PARITY_EN
                  par_err_q <= 1'b0;
`endif
                  state_q   <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (!expired) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  for (int i = 0; i < CODE_W; i++) begin
                     if (idx_q == IDX_W'(i)) begin
                        shift_q[i] <= rx_s;
                     end
                  end
                  cnt_q <= CNT_FULL;
                  if (idx_q == IDX_LAST) begin
`ifdef SERIAL_DECODER_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end

`ifdef SERIAL_DECODER_PARITY_EN
            ST_PARITY: begin
               if (!expired) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  par_err_q <= (rx_s != even_parity({{(8-CODE_W){1'b0}}, shift_q}));
                  cnt_q     <= CNT_FULL;
                  state_q   <= ST_STOP;
               end
            end
`endif

            ST_STOP: begin
               if (!expired) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
`ifdef SERIAL_DECODER_PARITY_EN
                  if ((rx_s == LINE_IDLE) && !par_err_q) begin
`else
                  if (rx_s == LINE_IDLE) begin
`endif
                     code_q   <= shift_q;
                     onehot_q <= OH_W'(1) << shift_q;
                     valid_q  <= 1'b1;
                  end else begin
                     err_q    <= 1'b1;
                  end
                  // Back in IDLE right away so an immediately following
                  // start edge is caught.
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign onehot = onehot_q;
   assign code   = code_q;
   assign valid  = valid_q;
   assign err    = err_q;
   assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_decoder.sv
// Self-checking bench for serial_decoder. Frames are generated bit by bit on
// rx; expectations come from a frame-level model (timing from frame length,
// code/onehot from the last good frame).
module tb_serial_decoder;

   localparam int CODE_W = 2;
   localparam int DIV    = 4;
   localparam int OH_W   = 1 << CODE_W;
`ifdef SERIAL_DECODER_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_LEN = (CODE_W + 2 + PAR_BITS) * DIV;
   // First-low period to result period: 2 sync flops, half bit, the
   // remaining bits up to mid-stop, then one cycle for the registered outputs.
   localparam int VALID_LAT = 2 + DIV/2 + (CODE_W + 1 + PAR_BITS) * DIV + 1;

   typedef struct {
      int                per;
      bit                is_err;
      logic [CODE_W-1:0] code;
      logic [OH_W-1:0]   onehot;
   } event_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              rx;
   logic [OH_W-1:0]   onehot;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic              busy;
   logic              err;

   int     cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   bit     both_seen = 1'b0;
   event_t obs_q[$];
   event_t exp_q[$];
   event_t mon_ev;
   logic [CODE_W-1:0] m_code;

   serial_decoder #(.CODE_W(CODE_W), .DIV(DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .onehot (onehot),
      .code   (code),
      .valid  (valid),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Records every valid/err pulse with the period it is observed in.
   always @(negedge clk) begin
      if (valid === 1'b1 || err === 1'b1) begin
         mon_ev.per    = cyc + 1;
         mon_ev.is_err = (err === 1'b1);
         mon_ev.code   = code;
         mon_ev.onehot = onehot;
         obs_q.push_back(mon_ev);
      end
      if (valid === 1'b1 && err === 1'b1) both_seen = 1'b1;
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame and appends the model's expected result to exp_q.
   task automatic send_frame(input logic [CODE_W-1:0] c, input bit bad_stop,
                             input bit bad_par, output int t0);
      logic [CODE_W-1:0] cv;
      logic              par_bit;
      event_t            e;
      bit                is_err;
      int                ones;
      cv = c;
      ones = 0;
      for (int i = 0; i < CODE_W; i++) ones += int'(cv[i]);
      par_bit = logic'(ones % 2) ^ bad_par;
      is_err = bad_stop || (PAR_BITS != 0 && bad_par);
      t0 = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < CODE_W; i++) drive_bit(cv[i]);
`ifdef SERIAL_DECODER_PARITY_EN
      drive_bit(par_bit);
`endif
      drive_bit(!bad_stop);
      if (!is_err) m_code = c;
      e.per    = t0 + VALID_LAT;
      e.is_err = is_err;
      e.code   = m_code;
      e.onehot = OH_W'(1) << m_code;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      if (onehot !== '0) begin n_fail++; $display("FAIL reset_onehot: got %b expected 0", onehot); end
      n_checks++;
      if (code !== '0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", code); end
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      rst = 1'b0;
      m_code = '0;
      idle(4);
   endtask

   task automatic test_single_frame();
      int t0;
      obs_q.delete(); exp_q.delete();
      send_frame(2'b10, 1'b0, 1'b0, t0);
      idle(8);
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d pulses expected 1", obs_q.size());
      end else begin
         if (obs_q[0].per != t0 + VALID_LAT) begin n_fail++; $display("FAIL single_time: got t0+%0d expected t0+%0d", obs_q[0].per - t0, VALID_LAT); end
         n_checks++;
         if (obs_q[0].is_err) begin n_fail++; $display("FAIL single_kind: got err expected valid"); end
         n_checks++;
         if (obs_q[0].code !== 2'd2) begin n_fail++; $display("FAIL single_code: got %0d expected 2", obs_q[0].code); end
         n_checks++;
         if (obs_q[0].onehot !== 4'b0100) begin n_fail++; $display("FAIL single_onehot: got %b expected 0100", obs_q[0].onehot); end
      end
      n_checks++;
      if (onehot !== 4'b0100 || code !== 2'd2) begin
         n_fail++; $display("FAIL single_hold: got %b/%0d expected 0100/2", onehot, code);
      end
      n_checks++;
   endtask

   task automatic test_back_to_back();
      int t0a, t0b;
      obs_q.delete(); exp_q.delete();
      send_frame(2'd3, 1'b0, 1'b0, t0a);
      send_frame(2'd0, 1'b0, 1'b0, t0b);
      idle(VALID_LAT + 4);
      if (obs_q.size() != 2) begin
         n_fail++; $display("FAIL b2b_count: got %0d pulses expected 2", obs_q.size());
      end else begin
         if (obs_q[0].per != t0a + VALID_LAT) begin n_fail++; $display("FAIL b2b_time0: got t0+%0d expected t0+%0d", obs_q[0].per - t0a, VALID_LAT); end
         n_checks++;
         if (obs_q[1].per - obs_q[0].per != FRAME_LEN) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", obs_q[1].per - obs_q[0].per, FRAME_LEN); end
         n_checks++;
         if (obs_q[0].onehot !== 4'b1000 || obs_q[0].is_err) begin n_fail++; $display("FAIL b2b_first: got %b err=%0d expected 1000 err=0", obs_q[0].onehot, obs_q[0].is_err); end
         n_checks++;
         if (obs_q[1].onehot !== 4'b0001 || obs_q[1].is_err) begin n_fail++; $display("FAIL b2b_second: got %b err=%0d expected 0001 err=0", obs_q[1].onehot, obs_q[1].is_err); end
      end
      n_checks++;
   endtask

   task automatic test_stop_error();
      int t0;
      obs_q.delete(); exp_q.delete();
      send_frame(2'd2, 1'b0, 1'b0, t0);
      idle(4);
      obs_q.delete();
      send_frame(2'd1, 1'b1, 1'b0, t0);
      idle(8);
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL stoperr_count: got %0d pulses expected 1", obs_q.size());
      end else begin
         if (!obs_q[0].is_err) begin n_fail++; $display("FAIL stoperr_kind: got valid expected err"); end
         n_checks++;
         if (obs_q[0].per != t0 + VALID_LAT) begin n_fail++; $display("FAIL stoperr_time: got t0+%0d expected t0+%0d", obs_q[0].per - t0, VALID_LAT); end
         n_checks++;
         if (obs_q[0].onehot !== 4'b0100 || obs_q[0].code !== 2'd2) begin n_fail++; $display("FAIL stoperr_hold: got %b/%0d expected 0100/2", obs_q[0].onehot, obs_q[0].code); end
      end
      n_checks++;
   endtask

   task automatic test_glitch();
      int t0, busy_cnt, last_b;
      idle(DIV);
      obs_q.delete();
      t0 = cyc + 1;
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      busy_cnt = 0;
      last_b = t0;
      for (int i = 0; i < 3 * DIV + 4; i++) begin
         if (busy === 1'b1) begin busy_cnt++; last_b = cyc + 1; end
         @(negedge clk);
      end
      if (busy_cnt < 1 || busy_cnt > DIV/2 + 2) begin n_fail++; $display("FAIL glitch_busy_len: got %0d expected 1..%0d", busy_cnt, DIV/2 + 2); end
      n_checks++;
      if (last_b > t0 + DIV/2 + 3) begin n_fail++; $display("FAIL glitch_busy_end: got t0+%0d expected <= t0+%0d", last_b - t0, DIV/2 + 3); end
      n_checks++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", obs_q.size()); end
      n_checks++;
   endtask

   task automatic test_reset_mid_frame();
      obs_q.delete();
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (DIV + 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      n_checks++;
      if (onehot !== '0 || code !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %b/%0d expected 0000/0", onehot, code); end
      n_checks++;
      rst = 1'b0;
      m_code = '0;
      repeat (2 * DIV) @(negedge clk);
      idle(VALID_LAT + 4);
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 0", obs_q.size()); end
      n_checks++;
   endtask

`ifdef SERIAL_DECODER_PARITY_EN
   task automatic test_parity();
      int t0;
      obs_q.delete(); exp_q.delete();
      send_frame(2'd3, 1'b0, 1'b1, t0);
      idle(8);
      if (obs_q.size() != 1 || !obs_q[0].is_err) begin
         n_fail++; $display("FAIL parity_bad: got %0d pulses expected one err", obs_q.size());
      end else if (obs_q[0].per != t0 + 21) begin
         n_fail++; $display("FAIL parity_bad_time: got t0+%0d expected t0+21", obs_q[0].per - t0);
      end
      n_checks++;
      obs_q.delete();
      send_frame(2'd3, 1'b0, 1'b0, t0);
      idle(8);
      if (obs_q.size() != 1 || obs_q[0].is_err || obs_q[0].onehot !== 4'b1000) begin
         n_fail++; $display("FAIL parity_good: got %0d pulses expected one valid with 1000", obs_q.size());
      end
      n_checks++;
   endtask
`endif

   task automatic test_random();
      int  t0, gap;
      bit  bad_stop, bad_par, last_bad;
      logic [CODE_W-1:0] c;
      obs_q.delete(); exp_q.delete();
      last_bad = 1'b0;
      for (int n = 0; n < 40; n++) begin
         gap = last_bad ? 2 + $urandom_range(0, 3) : $urandom_range(0, 3);
         if (gap > 0) idle(gap);
         c        = CODE_W'($urandom_range(0, OH_W - 1));
         bad_stop = ($urandom_range(0, 4) == 0);
         bad_par  = ($urandom_range(0, 4) == 0);
         send_frame(c, bad_stop, bad_par, t0);
         last_bad = bad_stop;
      end
      idle(VALID_LAT + 4);
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i].per != exp_q[i].per || obs_q[i].is_err != exp_q[i].is_err ||
                obs_q[i].code !== exp_q[i].code || obs_q[i].onehot !== exp_q[i].onehot) begin
               n_fail++;
               $display("FAIL rand_frame%0d: got per=%0d err=%0d code=%0d oh=%b expected per=%0d err=%0d code=%0d oh=%b",
                        i, obs_q[i].per, obs_q[i].is_err, obs_q[i].code, obs_q[i].onehot,
                        exp_q[i].per, exp_q[i].is_err, exp_q[i].code, exp_q[i].onehot);
            end
            n_checks++;
         end
      end
      n_checks++;
      if (both_seen !== 1'b0) begin n_fail++; $display("FAIL valid_err_overlap: got 1 expected 0"); end
      n_checks++;
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      m_code = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stop_error();
      test_glitch();
      test_reset_mid_frame();
`ifdef SERIAL_DECODER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
